// File: rtl/ex_ctrl_pkg.sv
// Shared definitions for the execute-stage hazard controller.
//   - Forward-select encodings driven onto the A/B operand muxes.
//   - Memory-wait FSM state encoding.
//   - Scoreboard slot flag struct. The destination register of a slot is
//     stored next to this struct in the top so that its width can follow
//     the RA_W parameter.
package ex_ctrl_pkg;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_EX  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  // Wide enough for MEM_TIMEOUT up to 255.
  localparam int CNT_W = 8;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_WAIT    = 2'd1,
    ST_RELEASE = 2'd2
  } wait_state_e;

  typedef struct packed {
    logic valid;
    logic wr;
    logic load;
    logic memop;
  } slot_flags_t;

endpackage

// File: rtl/ex_mem_wait_fsm.sv
// Data-memory wait controller.
// Ports:
//   clk, reset    : clock, synchronous active-high reset
//   mem_pending   : MEM slot holds a valid load/store
//   mem_ack       : data memory completes the current access
//   mem_req       : access request (suppressed in the RELEASE cycle)
//   freeze_all    : hold every pipeline register
//   err_timeout   : sticky, an access ran into MEM_TIMEOUT
//   state         : current FSM state (debug)
// Timing: the first frozen cycle is spent in RUN, followed by up to
// MEM_TIMEOUT cycles in WAIT (cnt = 1..MEM_TIMEOUT). If the last WAIT cycle
// still sees no ack, one RELEASE cycle lets the pipeline move on with the
// access abandoned.
module ex_mem_wait_fsm
  import ex_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_pending,
  input  logic        mem_ack,
  output logic        mem_req,
  output logic        freeze_all,
  output logic        err_timeout,
  output wait_state_e state
);

  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(MEM_TIMEOUT);

  wait_state_e      state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             err_nxt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_RUN;
      cnt         <= '0;
      err_timeout <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      err_timeout <= err_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    err_nxt    = err_timeout;
    mem_req    = 1'b0;
    freeze_all = 1'b0;
    case (state)
      ST_RUN: begin
        mem_req    = mem_pending;
        // An ack in the request cycle completes with zero wait.
        freeze_all = mem_pending & ~mem_ack;
        if (freeze_all) begin
          state_nxt = ST_WAIT;
          cnt_nxt   = CNT_W'(1);
        end
      end
      ST_WAIT: begin
        // The slots are frozen, so mem_pending stays high throughout WAIT.
        mem_req    = mem_pending;
        freeze_all = ~mem_ack;
        if (mem_ack) begin
          state_nxt = ST_RUN;
          cnt_nxt   = '0;
        end else if (cnt == TIMEOUT_CNT) begin
          state_nxt = ST_RELEASE;
          err_nxt   = 1'b1;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      ST_RELEASE: begin
        state_nxt = ST_RUN;
        cnt_nxt   = '0;
      end
      default: begin
        state_nxt = ST_RUN;
        cnt_nxt   = '0;
      end
    endcase
  end

endmodule

// File: rtl/ex_hazard_ctrl.sv
// Execute-stage interlock and forwarding controller.
// Tracks the instructions in EX and MEM in a two-slot shadow scoreboard,
// drives operand-forward selects, injects a bubble on load-use hazards,
// flushes decode on taken branches and freezes the pipeline while a data
// memory access waits for its acknowledge.
// Ports:
//   clk, reset                 : clock, synchronous active-high reset
//   dec_*                      : decode-stage instruction description
//   br_taken_ex                : branch resolved taken in EX
//   mem_ack                    : data memory completes the current access
//   fwd_a_sel, fwd_b_sel       : 00 regfile, 01 EX result, 10 MEM result
//   stall_dec, bubble_ex       : hold decode / insert NOP into EX
//   freeze_all, flush_dec      : hold everything / squash decode
//   mem_req, err_timeout       : memory request / sticky timeout flag
//   dbg_state                  : memory-wait FSM state (debug)
// Handshake: the memory access is a request/acknowledge pair; mem_req is
// held while MEM holds a load/store, and the access completes in the
// first cycle where mem_req and mem_ack are both high. mem_ack at any other
// time has no effect.
module ex_hazard_ctrl
  import ex_ctrl_pkg::*;
#(
  parameter int RA_W        = 5,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            dec_valid,
  input  logic [RA_W-1:0] dec_src_a,
  input  logic [RA_W-1:0] dec_src_b,
  input  logic            dec_use_a,
  input  logic            dec_use_b,
  input  logic [RA_W-1:0] dec_rw,
  input  logic            dec_wr,
  input  logic            dec_load,
  input  logic            dec_memop,
  input  logic            br_taken_ex,
  input  logic            mem_ack,
  output logic [1:0]      fwd_a_sel,
  output logic [1:0]      fwd_b_sel,
  output logic            stall_dec,
  output logic            bubble_ex,
  output logic            freeze_all,
  output logic            flush_dec,
  output logic            mem_req,
  output logic            err_timeout,
  output logic [1:0]      dbg_state
);

  slot_flags_t     ex_s;
  slot_flags_t     mem_s;
  logic [RA_W-1:0] ex_rw;
  logic [RA_W-1:0] mem_rw;
  wait_state_e     fsm_state;
  logic            load_use;

  ex_mem_wait_fsm #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_fsm (
    .clk         (clk),
    .reset       (reset),
    .mem_pending (mem_s.valid & mem_s.memop),
    .mem_ack     (mem_ack),
    .mem_req     (mem_req),
    .freeze_all  (freeze_all),
    .err_timeout (err_timeout),
    .state       (fsm_state)
  );

  assign dbg_state = fsm_state;

  // A load's data is not available in EX, so an EX-stage load never
  // forwards; the load-use interlock covers that case instead.
  function automatic logic [1:0] fwd_sel(input logic use_src,
                                         input logic [RA_W-1:0] src);
    logic [1:0] sel;
    sel = FWD_RF;
    if (use_src && ex_s.valid && ex_s.wr && !ex_s.load && src == ex_rw)
      sel = FWD_EX;
    else if (use_src && mem_s.valid && mem_s.wr && src == mem_rw)
      sel = FWD_MEM;
    return sel;
  endfunction

  always_comb begin
    fwd_a_sel = fwd_sel(dec_use_a, dec_src_a);
    fwd_b_sel = fwd_sel(dec_use_b, dec_src_b);
  end

  assign load_use = dec_valid && ex_s.valid && ex_s.load && ex_s.wr &&
                    ((dec_use_a && dec_src_a == ex_rw) ||
                     (dec_use_b && dec_src_b == ex_rw));

  // Freeze beats flush beats load-use. A branch seen during a freeze is
  // still presented by EX afterwards, so it takes effect then.
  always_comb begin
    stall_dec = 1'b0;
    bubble_ex = 1'b0;
    flush_dec = 1'b0;
    if (!freeze_all) begin
      if (br_taken_ex) begin
        flush_dec = 1'b1;
        bubble_ex = 1'b1;
      end else if (load_use) begin
        stall_dec = 1'b1;
        bubble_ex = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_s   <= '0;
      mem_s  <= '0;
      ex_rw  <= '0;
      mem_rw <= '0;
    end else if (!freeze_all) begin
      mem_s  <= ex_s;
      mem_rw <= ex_rw;
      if (bubble_ex) begin
        ex_s  <= '0;
        ex_rw <= '0;
      end else begin
        ex_s.valid <= dec_valid;
        ex_s.wr    <= dec_wr;
        ex_s.load  <= dec_load;
        ex_s.memop <= dec_memop;
        ex_rw      <= dec_rw;
      end
    end
  end

endmodule

// File: tb/tb_ex_hazard_ctrl.sv
// Directed bench for ex_hazard_ctrl. Each driven cycle pushes the expected
// output word; a negedge monitor pops and compares.
// Word layout: {state[1:0], fwd_a[1:0], fwd_b[1:0], stall, bubble, freeze,
//               flush, mem_req, err}
module tb_ex_hazard_ctrl;

  localparam int RA_W = 5;

  localparam logic [1:0] S_RUN = 2'd0;
  localparam logic [1:0] S_WAI = 2'd1;
  localparam logic [1:0] S_REL = 2'd2;
  localparam logic [1:0] F_RF  = 2'b00;
  localparam logic [1:0] F_EX  = 2'b01;
  localparam logic [1:0] F_ME  = 2'b10;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            dec_valid = 1'b0;
  logic [RA_W-1:0] dec_src_a = '0;
  logic [RA_W-1:0] dec_src_b = '0;
  logic            dec_use_a = 1'b0;
  logic            dec_use_b = 1'b0;
  logic [RA_W-1:0] dec_rw = '0;
  logic            dec_wr = 1'b0;
  logic            dec_load = 1'b0;
  logic            dec_memop = 1'b0;
  logic            br_taken_ex = 1'b0;
  logic            mem_ack = 1'b0;
  logic [1:0]      fwd_a_sel;
  logic [1:0]      fwd_b_sel;
  logic            stall_dec;
  logic            bubble_ex;
  logic            freeze_all;
  logic            flush_dec;
  logic            mem_req;
  logic            err_timeout;
  logic [1:0]      dbg_state;

  logic [11:0] exp_q[$];
  int          id_q[$];
  int          n_vec  = 0;
  int          n_miss = 0;
  int          vec_id = 0;

  ex_hazard_ctrl #(
    .RA_W        (RA_W),
    .MEM_TIMEOUT (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .dec_valid   (dec_valid),
    .dec_src_a   (dec_src_a),
    .dec_src_b   (dec_src_b),
    .dec_use_a   (dec_use_a),
    .dec_use_b   (dec_use_b),
    .dec_rw      (dec_rw),
    .dec_wr      (dec_wr),
    .dec_load    (dec_load),
    .dec_memop   (dec_memop),
    .br_taken_ex (br_taken_ex),
    .mem_ack     (mem_ack),
    .fwd_a_sel   (fwd_a_sel),
    .fwd_b_sel   (fwd_b_sel),
    .stall_dec   (stall_dec),
    .bubble_ex   (bubble_ex),
    .freeze_all  (freeze_all),
    .flush_dec   (flush_dec),
    .mem_req     (mem_req),
    .err_timeout (err_timeout),
    .dbg_state   (dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  function automatic logic [11:0] e(input logic [1:0] st, input logic [1:0] fa,
                                    input logic [1:0] fb, input logic stl,
                                    input logic bub, input logic frz,
                                    input logic fl, input logic mr,
                                    input logic er);
    return {st, fa, fb, stl, bub, frz, fl, mr, er};
  endfunction

  task automatic zero_inputs();
    dec_valid = 0; dec_src_a = '0; dec_src_b = '0; dec_use_a = 0;
    dec_use_b = 0; dec_rw = '0; dec_wr = 0; dec_load = 0; dec_memop = 0;
    br_taken_ex = 0; mem_ack = 0;
  endtask

  // Driver: reset is applied for one cycle with no check in that cycle.
  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    zero_inputs();
  endtask

  task automatic drive(input logic dv, input int sa, input int sb,
                       input logic ua, input logic ub, input int rw,
                       input logic wr, input logic ld, input logic mop,
                       input logic br, input logic ack, input logic [11:0] ex);
    @(posedge clk); #1;
    reset       = 1'b0;
    dec_valid   = dv;
    dec_src_a   = RA_W'(sa);
    dec_src_b   = RA_W'(sb);
    dec_use_a   = ua;
    dec_use_b   = ub;
    dec_rw      = RA_W'(rw);
    dec_wr      = wr;
    dec_load    = ld;
    dec_memop   = mop;
    br_taken_ex = br;
    mem_ack     = ack;
    exp_q.push_back(ex);
    id_q.push_back(vec_id);
    vec_id++;
  endtask

  task automatic idle(input logic ack, input logic [11:0] ex);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ack, ex);
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    logic [11:0] act;
    logic [11:0] ex;
    int          id;
    if (exp_q.size() != 0) begin
      ex  = exp_q.pop_front();
      id  = id_q.pop_front();
      act = {dbg_state, fwd_a_sel, fwd_b_sel, stall_dec, bubble_ex,
             freeze_all, flush_dec, mem_req, err_timeout};
      n_vec++;
      if (act !== ex) begin
        n_miss++;
        $display("FAIL vec%0d st/fa/fb/stl/bub/frz/fl/mr/er got %b_%b_%b_%b%b%b%b%b%b expected %b_%b_%b_%b%b%b%b%b%b",
                 id, act[11:10], act[9:8], act[7:6], act[5], act[4], act[3],
                 act[2], act[1], act[0], ex[11:10], ex[9:8], ex[7:6], ex[5],
                 ex[4], ex[3], ex[2], ex[1], ex[0]);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [11:0] z;
    z = e(S_RUN, F_RF, F_RF, 0, 0, 0, 0, 0, 0);
    do_reset();
    // Reset state
    idle(0, z);
    // Forwarding: EX, then MEM, then register file
    drive(1, 1, 2, 1, 1, 3, 1, 0, 0, 0, 0, z);                                // ADD r3
    drive(1, 3, 0, 1, 0, 0, 0, 0, 0, 0, 0, e(S_RUN, F_EX, F_RF, 0,0,0,0,0,0));
    drive(1, 3, 3, 1, 1, 0, 0, 0, 0, 0, 0, e(S_RUN, F_ME, F_ME, 0,0,0,0,0,0));
    drive(1, 3, 0, 1, 0, 0, 0, 0, 0, 0, 0, z);
    // EX match beats MEM match
    drive(1, 0, 0, 0, 0, 3, 1, 0, 0, 0, 0, z);
    drive(1, 7, 0, 1, 0, 3, 1, 0, 0, 0, 0, z);
    drive(1, 3, 3, 1, 1, 0, 0, 0, 0, 0, 0, e(S_RUN, F_EX, F_EX, 0,0,0,0,0,0));
    // Register 0 forwards like any other; unused operand never forwards
    drive(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, z);
    drive(1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, e(S_RUN, F_EX, F_RF, 0,0,0,0,0,0));
    idle(0, z);
    // Load-use on B: one stall/bubble, then MEM forward with zero-wait ack
    drive(1, 1, 0, 1, 0, 5, 1, 1, 1, 0, 0, z);                                // LOAD r5
    drive(1, 0, 5, 0, 1, 6, 1, 0, 0, 0, 0, e(S_RUN, F_RF, F_RF, 1,1,0,0,0,0));
    drive(1, 0, 5, 0, 1, 6, 1, 0, 0, 0, 1, e(S_RUN, F_RF, F_ME, 0,0,0,0,1,0));
    idle(0, z);
    // Store waits three cycles for ack; slots hold (fwd_a stays EX)
    drive(1, 1, 2, 1, 1, 0, 0, 0, 1, 0, 0, z);                                // STORE
    drive(1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 0, z);                                // ADD r7
    drive(1, 7, 0, 1, 0, 0, 0, 0, 0, 0, 0, e(S_RUN, F_EX, F_RF, 0,0,1,0,1,0));
    drive(1, 7, 0, 1, 0, 0, 0, 0, 0, 0, 0, e(S_WAI, F_EX, F_RF, 0,0,1,0,1,0));
    drive(1, 7, 0, 1, 0, 0, 0, 0, 0, 0, 0, e(S_WAI, F_EX, F_RF, 0,0,1,0,1,0));
    drive(1, 7, 0, 1, 0, 0, 0, 0, 0, 0, 1, e(S_WAI, F_EX, F_RF, 0,0,0,0,1,0));
    drive(1, 7, 0, 1, 0, 0, 0, 0, 0, 0, 0, e(S_RUN, F_ME, F_RF, 0,0,0,0,0,0));
    idle(1, z);                                                               // stray ack ignored
    // Timeout: RUN cycle + 4 WAIT cycles frozen, then RELEASE
    drive(1, 0, 0, 0, 0, 9, 1, 1, 1, 0, 0, z);                                // LOAD r9
    idle(0, z);
    idle(0, e(S_RUN, F_RF, F_RF, 0,0,1,0,1,0));
    for (int i = 0; i < 4; i++) idle(0, e(S_WAI, F_RF, F_RF, 0,0,1,0,1,0));
    drive(1, 9, 0, 1, 0, 0, 0, 0, 0, 0, 0, e(S_REL, F_ME, F_RF, 0,0,0,0,0,1));
    idle(0, e(S_RUN, F_RF, F_RF, 0,0,0,0,0,1));
    // Load-use together with taken branch: flush wins, no stall
    drive(1, 0, 0, 0, 0, 4, 1, 1, 1, 0, 0, e(S_RUN, F_RF, F_RF, 0,0,0,0,0,1)); // LOAD r4
    drive(1, 4, 0, 1, 0, 0, 0, 0, 0, 1, 0, e(S_RUN, F_RF, F_RF, 0,1,0,1,0,1));
    idle(1, e(S_RUN, F_RF, F_RF, 0,0,0,0,1,1));
    // Reset during WAIT; branch during freeze is masked
    drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, e(S_RUN, F_RF, F_RF, 0,0,0,0,0,1)); // STORE
    idle(0, e(S_RUN, F_RF, F_RF, 0,0,0,0,0,1));
    idle(0, e(S_RUN, F_RF, F_RF, 0,0,1,0,1,1));
    idle(0, e(S_WAI, F_RF, F_RF, 0,0,1,0,1,1));
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, e(S_WAI, F_RF, F_RF, 0,0,1,0,1,1));
    do_reset();
    idle(0, z);
    idle(0, z);

    @(negedge clk); #1;
    if (exp_q.size() != 0) begin
      n_miss++;
      $display("FAIL drain: %0d expected words left, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
